// File: rtl/bless_router_param.sv
// Bufferless deflection (BLESS) mesh router: stage-1 input registers, combinational
// age-ranked allocation with single ejection and FIFO injection, registered outputs.
module bless_router_param #(
  parameter int DATA_W    = 32,
  parameter int COORD_W   = 2,
  parameter int AGE_W     = 4,
  parameter int INJ_DEPTH = 4,
  parameter int X_POS     = 0,
  parameter int Y_POS     = 0,
  localparam int FLIT_W   = 1 + AGE_W + 2 * COORD_W + DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] dinW,
  input  logic [FLIT_W-1:0] dinE,
  input  logic [FLIT_W-1:0] dinS,
  input  logic [FLIT_W-1:0] dinN,
  input  logic [FLIT_W-1:0] inj_flit,
  input  logic              inj_valid,
  output logic              inj_ready,
  output logic [FLIT_W-1:0] doutW,
  output logic [FLIT_W-1:0] doutE,
  output logic [FLIT_W-1:0] doutS,
  output logic [FLIT_W-1:0] doutN,
  output logic [FLIT_W-1:0] doutLocal,
  output logic [15:0]       stat_deflect
);

  localparam int BODY_W = 2 * COORD_W + DATA_W;
  localparam int PTR_W  = (INJ_DEPTH > 1) ? $clog2(INJ_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_POS);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_POS);

  localparam logic [2:0] PORT_W = 3'd0;
  localparam logic [2:0] PORT_E = 3'd1;
  localparam logic [2:0] PORT_S = 3'd2;
  localparam logic [2:0] PORT_N = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;

  function automatic logic [2:0] routeOf(input logic [BODY_W-1:0] body);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = body[BODY_W-1 -: COORD_W];
    dy = body[BODY_W-COORD_W-1 -: COORD_W];
    if (dx > X_C)      routeOf = PORT_E;
    else if (dx < X_C) routeOf = PORT_W;
    else if (dy > Y_C) routeOf = PORT_N;
    else if (dy < Y_C) routeOf = PORT_S;
    else               routeOf = PORT_L;
  endfunction

  function automatic logic [1:0] firstFree(input logic [3:0] taken);
    firstFree = 2'd0;
    for (int p = 3; p >= 0; p--) begin
      if (!taken[p]) firstFree = 2'(p);
    end
  endfunction

  function automatic logic [FLIT_W-1:0] ageUp(input logic [FLIT_W-1:0] f);
    logic [AGE_W-1:0] a;
    a = f[FLIT_W-2 -: AGE_W];
    if (a != '1) a = a + AGE_W'(1);
    ageUp = {f[FLIT_W-1], a, f[BODY_W-1:0]};
  endfunction

  logic [FLIT_W-1:0] stage1 [4];
  logic [BODY_W-1:0] fifoMem [INJ_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  fifoCount;
  logic [BODY_W-1:0] fifoHead;
  logic              push;
  logic              pop;
  logic              unusedInjBits;

  logic [FLIT_W-1:0] outNext [4];
  logic [FLIT_W-1:0] localNext;
  logic [3:0]        taken;
  logic [3:0]        valid;
  logic [AGE_W-1:0]  age [4];
  logic [1:0]        rank [4];
  logic [2:0]        route;
  logic [1:0]        port;
  logic              ejected;
  logic [2:0]        deflects;
  logic [16:0]       statSum;

  // Injected flits have valid/age rebuilt, so only the body is stored.
  assign unusedInjBits = ^inj_flit[FLIT_W-1:BODY_W];
  assign inj_ready     = (fifoCount != CNT_W'(INJ_DEPTH));
  assign push          = inj_valid && inj_ready;
  assign fifoHead      = fifoMem[rdPtr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) stage1[i] <= '0;
    end else begin
      stage1[0] <= dinW;
      stage1[1] <= dinE;
      stage1[2] <= dinS;
      stage1[3] <= dinN;
    end
  end

  always_ff @(posedge clk) begin
    if (push && reset) fifoMem[wrPtr] <= inj_flit[BODY_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      fifoCount <= fifoCount + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      outNext[i] = '0;
      valid[i]   = stage1[i][FLIT_W-1];
      age[i]     = stage1[i][FLIT_W-2 -: AGE_W];
      rank[i]    = '0;
    end
    localNext = '0;
    taken     = '0;
    deflects  = '0;
    pop       = 1'b0;
    ejected   = 1'b0;
    route     = PORT_L;
    port      = '0;

    // Rank = number of valid flits that beat this one (older, or same age and earlier port).
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j != i && valid[j] && (age[j] > age[i] || (age[j] == age[i] && j < i)))
          rank[i] = rank[i] + 2'd1;
      end
    end

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (valid[i] && rank[i] == 2'(r)) begin
          route = routeOf(stage1[i][BODY_W-1:0]);
          if (route == PORT_L && !ejected) begin
            ejected   = 1'b1;
            localNext = stage1[i];
          end else begin
            if (route != PORT_L && !taken[route[1:0]]) begin
              port = route[1:0];
            end else begin
              port     = firstFree(taken);
              deflects = deflects + 3'd1;
            end
            taken[port]   = 1'b1;
            outNext[port] = ageUp(stage1[i]);
          end
        end
      end
    end

    // Injection only uses a port left over after all mesh flits are placed.
    if (fifoCount != '0 && taken != 4'hF) begin
      route = routeOf(fifoHead);
      if (route != PORT_L && !taken[route[1:0]]) port = route[1:0];
      else                                       port = firstFree(taken);
      taken[port]   = 1'b1;
      outNext[port] = {1'b1, AGE_W'(1), fifoHead};
      pop           = 1'b1;
    end
  end

  assign statSum = {1'b0, stat_deflect} + 17'(deflects);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      doutW        <= '0;
      doutE        <= '0;
      doutS        <= '0;
      doutN        <= '0;
      doutLocal    <= '0;
      stat_deflect <= '0;
    end else begin
      doutW        <= outNext[0];
      doutE        <= outNext[1];
      doutS        <= outNext[2];
      doutN        <= outNext[3];
      doutLocal    <= localNext;
      stat_deflect <= statSum[16] ? 16'hFFFF : statSum[15:0];
    end
  end

endmodule

// File: tb/tb_bless_router_param.sv
// Directed bench for bless_router_param at mesh position (1,1): vector table for
// single-cycle allocation plus sequences for injection, FIFO full, saturation and reset.
module tb_bless_router_param;

  localparam int DATA_W  = 32;
  localparam int COORD_W = 2;
  localparam int AGE_W   = 4;
  localparam int FW      = 1 + AGE_W + 2 * COORD_W + DATA_W;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] dinW, dinE, dinS, dinN;
  logic [FW-1:0] inj_flit;
  logic          inj_valid;
  logic          inj_ready;
  logic [FW-1:0] doutW, doutE, doutS, doutN, doutLocal;
  logic [15:0]   stat_deflect;

  int checkCount = 0;
  int passCount  = 0;
  int expStat    = 0;

  typedef struct {
    logic [FW-1:0] w, e, s, n;
    logic [FW-1:0] ew, ee, es, en, el;
    int            defl;
  } vec_t;

  vec_t vecs [7];

  bless_router_param #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .AGE_W(AGE_W),
    .INJ_DEPTH(4), .X_POS(1), .Y_POS(1)
  ) dut (
    .clk(clk), .reset(reset),
    .dinW(dinW), .dinE(dinE), .dinS(dinS), .dinN(dinN),
    .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .doutW(doutW), .doutE(doutE), .doutS(doutS), .doutN(doutN),
    .doutLocal(doutLocal), .stat_deflect(stat_deflect)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic v, input int a, input int dx, input int dy,
                                       input logic [31:0] pl);
    logic [FW-1:0] f;
    f = {v, 4'(a), 2'(dx), 2'(dy), pl};
    return f;
  endfunction

  function automatic vec_t mkVec(input logic [FW-1:0] w, e, s, n, ew, ee, es, en, el,
                                 input int d);
    vec_t t;
    t.w = w; t.e = e; t.s = s; t.n = n;
    t.ew = ew; t.ee = ee; t.es = es; t.en = en; t.el = el;
    t.defl = d;
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic addStat(input int n);
    expStat = expStat + n;
    if (expStat > 65535) expStat = 65535;
  endtask

  task automatic applyStimulus(input logic [FW-1:0] w, e, s, n);
    dinW = w; dinE = e; dinS = s; dinN = n;
  endtask

  task automatic checkOutput(input string name, input logic [FW-1:0] actual,
                             input logic [FW-1:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkPorts(input string tag, input logic [FW-1:0] ew, ee, es, en, el);
    checkOutput($sformatf("%s doutW", tag), doutW, ew);
    checkOutput($sformatf("%s doutE", tag), doutE, ee);
    checkOutput($sformatf("%s doutS", tag), doutS, es);
    checkOutput($sformatf("%s doutN", tag), doutN, en);
    checkOutput($sformatf("%s doutLocal", tag), doutLocal, el);
    checkOutput($sformatf("%s stat", tag), FW'(stat_deflect), FW'(expStat));
  endtask

  localparam logic [FW-1:0] Z = '0;

  initial begin
    // Single-flit east route
    vecs[0] = mkVec(mk(1,2,3,1,32'hA0000001), Z, Z, Z,
                    Z, mk(1,3,3,1,32'hA0000001), Z, Z, Z, 0);
    // Older W flit wins E; S flit deflected to W
    vecs[1] = mkVec(mk(1,5,3,1,32'hB1), Z, mk(1,2,3,1,32'hB2), Z,
                    mk(1,3,3,1,32'hB2), mk(1,6,3,1,32'hB1), Z, Z, Z, 1);
    // Local tie: E ejected unchanged, N deflected to W
    vecs[2] = mkVec(Z, mk(1,1,1,1,32'hC3), Z, mk(1,1,1,1,32'hC4),
                    mk(1,2,1,1,32'hC4), Z, Z, Z, mk(1,1,1,1,32'hC3), 1);
    // Four flits, four distinct productive ports
    vecs[3] = mkVec(mk(1,1,3,1,32'hD1), mk(1,2,0,1,32'hD2), mk(1,3,1,3,32'hD3), mk(1,0,1,0,32'hD4),
                    mk(1,3,0,1,32'hD2), mk(1,2,3,1,32'hD1), mk(1,1,1,0,32'hD4), mk(1,4,1,3,32'hD3),
                    Z, 0);
    // All want N: ranking N(7) > E(3) > S(3) > W(0)
    vecs[4] = mkVec(mk(1,0,1,3,32'hE1), mk(1,3,1,3,32'hE2), mk(1,3,1,3,32'hE3), mk(1,7,1,3,32'hE4),
                    mk(1,4,1,3,32'hE2), mk(1,4,1,3,32'hE3), mk(1,1,1,3,32'hE1), mk(1,8,1,3,32'hE4),
                    Z, 3);
    // Age saturation at 15, plus 14 -> 15 on deflection
    vecs[5] = mkVec(mk(1,15,1,0,32'hF1), mk(1,14,1,0,32'hF2), Z, Z,
                    mk(1,15,1,0,32'hF2), Z, mk(1,15,1,0,32'hF1), Z, Z, 1);
    // All local: W ejected, rest deflected W,E,S
    vecs[6] = mkVec(mk(1,0,1,1,32'h11), mk(1,0,1,1,32'h12), mk(1,0,1,1,32'h13), mk(1,0,1,1,32'h14),
                    mk(1,1,1,1,32'h12), mk(1,1,1,1,32'h13), mk(1,1,1,1,32'h14), Z,
                    mk(1,0,1,1,32'h11), 3);

    // Reset state; a push offered during reset must be dropped
    reset = 1'b0;
    applyStimulus(Z, Z, Z, Z);
    inj_valid = 1'b1;
    inj_flit  = mk(1, 0, 1, 3, 32'hDEAD0000);
    repeat (3) tick;
    checkPorts("reset", Z, Z, Z, Z, Z);
    checkOutput("reset inj_ready", FW'(inj_ready), FW'(1));
    inj_valid = 1'b0;
    reset     = 1'b1;
    tick;
    tick;
    checkPorts("post-reset", Z, Z, Z, Z, Z);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].w, vecs[v].e, vecs[v].s, vecs[v].n);
      tick;
      applyStimulus(Z, Z, Z, Z);
      tick;
      addStat(vecs[v].defl);
      checkPorts($sformatf("vec%0d", v), vecs[v].ew, vecs[v].ee, vecs[v].es, vecs[v].en, vecs[v].el);
    end
    tick;

    // Injection blocked by a full mesh, then released; valid/age of inj_flit ignored
    applyStimulus(vecs[3].w, vecs[3].e, vecs[3].s, vecs[3].n);
    inj_valid = 1'b1;
    inj_flit  = mk(0, 9, 1, 3, 32'hB0B00001);
    tick;
    applyStimulus(Z, Z, Z, Z);
    inj_valid = 1'b0;
    tick;
    checkPorts("blocked", vecs[3].ew, vecs[3].ee, vecs[3].es, vecs[3].en, Z);
    checkOutput("blocked inj_ready", FW'(inj_ready), FW'(1));
    tick;
    checkPorts("inject", Z, Z, Z, mk(1, 1, 1, 3, 32'hB0B00001), Z);
    tick;
    checkPorts("drained", Z, Z, Z, Z, Z);

    // FIFO fills while the mesh stays busy; fifth push dropped
    for (int k = 0; k < 5; k++) begin
      applyStimulus(vecs[3].w, vecs[3].e, vecs[3].s, vecs[3].n);
      inj_valid = 1'b1;
      inj_flit  = mk(0, 0, 1, 3, 32'hC0DE0000 + 32'(k));
      tick;
      if (k >= 1) checkOutput($sformatf("busy%0d doutN", k), doutN, vecs[3].en);
      if (k >= 3) checkOutput($sformatf("full%0d inj_ready", k), FW'(inj_ready), FW'(0));
    end
    applyStimulus(Z, Z, Z, Z);
    inj_valid = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      tick;
      checkPorts($sformatf("drain%0d", k), Z, Z, Z, mk(1, 1, 1, 3, 32'hC0DE0000 + 32'(k)), Z);
      if (k == 0) checkOutput("drain inj_ready", FW'(inj_ready), FW'(1));
    end
    tick;
    checkPorts("fifth-dropped", Z, Z, Z, Z, Z);

    // Deflection counter saturation
    applyStimulus(vecs[6].w, vecs[6].e, vecs[6].s, vecs[6].n);
    repeat (21900) tick;
    applyStimulus(Z, Z, Z, Z);
    tick;
    tick;
    addStat(3 * 21900);
    checkPorts("saturated", Z, Z, Z, Z, Z);

    // Reset mid-operation with queued and in-flight flits
    for (int k = 0; k < 3; k++) begin
      applyStimulus(vecs[3].w, vecs[3].e, vecs[3].s, vecs[3].n);
      inj_valid = 1'b1;
      inj_flit  = mk(0, 0, 1, 3, 32'hD0000000 + 32'(k));
      tick;
    end
    reset = 1'b0;
    applyStimulus(Z, Z, Z, Z);
    inj_valid = 1'b0;
    #2;
    expStat = 0;
    checkPorts("mid-reset", Z, Z, Z, Z, Z);
    checkOutput("mid-reset inj_ready", FW'(inj_ready), FW'(1));
    tick;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checkPorts($sformatf("after-reset%0d", c), Z, Z, Z, Z, Z);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bless_router_param.md
BLESS_ROUTER_PARAM -- requirements
Module: bless_router_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width.
REQ-002 SHALL have parameter COORD_W, default 2, width of each destination coordinate.
REQ-003 SHALL have parameter AGE_W, default 4, width of the flit age field.
REQ-004 SHALL have parameter INJ_DEPTH, default 4, local injection FIFO depth (power of 2, >=2).
REQ-005 SHALL have parameters X_POS and Y_POS, default 0, router mesh coordinates.
REQ-006 SHALL derive FLIT_W = 1+AGE_W+2*COORD_W+DATA_W; flit fields MSB to LSB: valid, age, dst_x, dst_y, payload.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 dinW, dinE, dinS, dinN  input  FLIT_W each  mesh input flits; a flit is present when its valid bit is 1.
REQ-010 inj_flit  input  FLIT_W  local flit to inject; its valid and age bits are ignored.
REQ-011 inj_valid  input  1  inj_flit is offered.
REQ-012 inj_ready  output  1  FIFO not full; a push occurs when inj_valid and inj_ready are both 1.
REQ-013 doutW, doutE, doutS, doutN  output  FLIT_W each  registered mesh output flits.
REQ-014 doutLocal  output  FLIT_W  registered ejected flit.
REQ-015 stat_deflect  output  16  saturating count of deflected flits.

Function
REQ-016 SHALL register all four mesh inputs (stage 1), then allocate, then register outputs (stage 2): a flit sampled at edge N SHALL appear on an output after edge N+1. This is a fixed 2-edge latency.
REQ-017 SHALL use XY route compute per flit:
- dst_x>X_POS gives E; dst_x<X_POS gives W.
- Otherwise dst_y>Y_POS gives N; dst_y<Y_POS gives S.
- Otherwise local.
REQ-018 SHALL rank valid stage-1 flits by age, oldest first; ties SHALL be broken by fixed order W>E>S>N.
REQ-019 SHALL eject at most one flit per cycle: the highest-ranked local-destined flit goes to doutLocal unchanged.
REQ-020 Each remaining flit, in rank order, SHALL take its productive mesh port if that port is still free.
REQ-021 If the productive port is taken, or the flit is local-destined but not ejected, the flit SHALL be deflected to the first free port in order W,E,S,N.
REQ-022 Every deflected flit SHALL increment stat_deflect by 1 (multiple per cycle summed); stat_deflect SHALL saturate at 16'hFFFF.
REQ-023 The FIFO head SHALL be injected in a cycle only when at least one mesh output remains free after REQ-019 to REQ-021.
REQ-024 An injected flit SHALL get valid=1 and age=0. It SHALL take its productive port if free, else the first free port in order W,E,S,N; this SHALL NOT count as a deflection.
REQ-025 A local-destined injected flit is illegal input and its behaviour is undefined.
REQ-026 SHALL pop the FIFO on injection. SHALL NOT bypass: a flit pushed at edge N SHALL be injectable no earlier than the allocation following edge N.
REQ-027 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-028 Pointers SHALL wrap modulo INJ_DEPTH; inj_ready SHALL be 0 exactly when occupancy equals INJ_DEPTH.
REQ-029 Every flit leaving on a mesh port SHALL have its age incremented by 1, saturating at 2^AGE_W-1.
REQ-030 Unused outputs SHALL be all-zero. Flit conservation SHALL hold: mesh outputs valid = inputs valid - ejected + injected.
REQ-031 Allocation SHALL be combinational between the stage registers; there are no internal flit buffers other than the injection FIFO.

Reset
REQ-032 While reset=0, all stage registers, all dout* and stat_deflect SHALL be 0 and the FIFO empty.
REQ-033 While reset=0, inj_ready SHALL read 1 but pushes SHALL be ignored.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight and queued flits immediately, with no partial output on release.

Verification (X_POS=1, Y_POS=1, defaults)
REQ-035 doutE: dinW valid, dst=(3,1), age=2 at edge 0 -> doutE carries it with age=3 after edge 1; all other outputs 0.
REQ-036 Contention deflection: dinW age=5 and dinS age=2, both dst=(3,1) -> doutE carries the W flit with age=6; doutW carries the S flit with age=3; stat_deflect=1.
REQ-037 Local tie: dinE and dinN both dst=(1,1), age=1 -> doutLocal carries the E flit with age=1; the N flit goes to doutW with age=2; stat_deflect=1.
REQ-038 Injection blocked then released: 4 valid non-local mesh flits plus 1 queued inject -> no injection and FIFO occupancy stays 1. Next cycle with no mesh input -> inject flit dst=(1,3) appears on doutN with age=1 and the FIFO is empty.
REQ-039 FIFO full and age saturation: 4 pushes with every mesh port busy -> inj_ready=0 after the 4th push and a 5th push is ignored. An input flit with age=15 leaves with age=15.
REQ-040 Reset mid-operation: with the FIFO at 3 and flits in stage 1, pulse reset=0 -> all outputs 0 and inj_ready=1. After release with no stimulus, outputs stay 0 for 3 cycles.
